// File: rtl/user_led_button_ctrl_if.sv
// user_led_button_ctrl_if
//   Groups the button inputs, the 10kHz enable and the LED settings outputs
//   of user_led_button_ctrl.
//   Signal timing: there is no valid/ready pairing on this bus.
//     - btn is a raw asynchronous level.
//     - ce_10khz is a one-clock strobe.
//     - Every settings output is a registered level that holds until a
//       button press changes it.
//   Modports:
//     master : drives ce_10khz/btn, observes the settings (bench / upstream).
//     slave  : the controller itself.
interface user_led_button_ctrl_if;
  logic       ce_10khz;    // one-cycle enable at 10kHz
  logic [3:0] btn;         // [0]=mode [1]=inc [2]=dec [3]=invert, raw, active-high
  logic [9:0] timer;       // rainbow transition timer
  logic [6:0] brightness;  // rainbow brightness 0..100
  logic       inverted;    // inverted colour transition
  logic       fixed_mode;  // fixed-colour duties selected downstream
  logic [6:0] duty_r;      // fixed red duty 0..100
  logic [6:0] duty_g;      // fixed green duty 0..100
  logic [6:0] duty_b;      // fixed blue duty 0..100
  logic [2:0] state;       // current mode state, for status LEDs

  modport master (
    output ce_10khz, btn,
    input  timer, brightness, inverted, fixed_mode, duty_r, duty_g, duty_b, state
  );

  modport slave (
    input  ce_10khz, btn,
    output timer, brightness, inverted, fixed_mode, duty_r, duty_g, duty_b, state
  );
endinterface

// File: rtl/user_led_button_ctrl.sv
// user_led_button_ctrl
//   Push-button front end for the user-LED block.
//   Each of four buttons is synchronised, then debounced on the 10kHz
//   enable, and turned into a one-clock press pulse.
//   The press pulses drive a five-state mode machine that selects which
//   setting the inc/dec buttons adjust.
//   Ports:
//     clk : 100MHz clock
//     rst : asynchronous assert, synchronous release, active-high
//     bus : user_led_button_ctrl_if.slave. Inputs are ce_10khz and btn;
//           outputs are the LED settings plus the current state.
module user_led_button_ctrl #(
  parameter int         P_DEBOUNCE_TICKS = 200,
  parameter int         P_DB_WIDTH       = 8,
  parameter logic [6:0] P_BRIGHT_INIT    = 7'd50,
  parameter logic [6:0] P_BRIGHT_STEP    = 7'd10,
  parameter logic [9:0] P_TIMER_INIT     = 10'h0FF,
  parameter logic [9:0] P_TIMER_STEP     = 10'h040
) (
  input  logic                   clk,
  input  logic                   rst,
  user_led_button_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_BRIGHT = 3'd0,
    S_SPEED  = 3'd1,
    S_FIX_R  = 3'd2,
    S_FIX_G  = 3'd3,
    S_FIX_B  = 3'd4
  } state_t;

  localparam logic [P_DB_WIDTH-1:0] DB_LAST = P_DB_WIDTH'(P_DEBOUNCE_TICKS - 1);

  logic [3:0]            sync1, sync2;
  logic [3:0]            stable, stable_d, press;
  logic [P_DB_WIDTH-1:0] db_cnt [4];

  // Two-flop synchroniser on every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
    end
  end

  // Debounce: a differing level must be seen on P_DEBOUNCE_TICKS consecutive
  // ticks; the last of those ticks flips the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else if (bus.ce_10khz) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press pulse is registered: high the cycle after stable rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= '0;
      press    <= '0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

  logic mode_p, inc_p, dec_p, inv_p, adj_en;
  assign mode_p = press[0];
  assign inc_p  = press[1];
  assign dec_p  = press[2];
  assign inv_p  = press[3];
  // A mode press wins over inc/dec; inc and dec together cancel.
  assign adj_en = !mode_p && (inc_p ^ dec_p);

  // Saturating arithmetic; the wider intermediate keeps the sum from wrapping.
  function automatic logic [6:0] pct_inc(input logic [6:0] v);
    logic [7:0] s;
    s = {1'b0, v} + {1'b0, P_BRIGHT_STEP};
    return (s > 8'd100) ? 7'd100 : s[6:0];
  endfunction

  function automatic logic [6:0] pct_dec(input logic [6:0] v);
    return (v < P_BRIGHT_STEP) ? 7'd0 : v - P_BRIGHT_STEP;
  endfunction

  function automatic logic [9:0] tmr_inc(input logic [9:0] v);
    logic [10:0] s;
    s = {1'b0, v} + {1'b0, P_TIMER_STEP};
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

  function automatic logic [9:0] tmr_dec(input logic [9:0] v);
    return (v < P_TIMER_STEP) ? 10'd0 : v - P_TIMER_STEP;
  endfunction

  state_t     state_q, state_n;
  logic [9:0] timer_q, timer_n;
  logic [6:0] bright_q, bright_n, r_q, r_n, g_q, g_n, b_q, b_n;
  logic       inv_q, inv_n, fixed_q, fixed_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_BRIGHT;
      timer_q  <= P_TIMER_INIT;
      bright_q <= P_BRIGHT_INIT;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      inv_q    <= 1'b0;
      fixed_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      timer_q  <= timer_n;
      bright_q <= bright_n;
      r_q      <= r_n;
      g_q      <= g_n;
      b_q      <= b_n;
      inv_q    <= inv_n;
      fixed_q  <= fixed_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    timer_n  = timer_q;
    bright_n = bright_q;
    r_n      = r_q;
    g_n      = g_q;
    b_n      = b_q;
    inv_n    = inv_q ^ inv_p;

    case (state_q)
      S_BRIGHT: if (mode_p) state_n = S_SPEED;
      S_SPEED:  if (mode_p) state_n = S_FIX_R;
      S_FIX_R:  if (mode_p) state_n = S_FIX_G;
      S_FIX_G:  if (mode_p) state_n = S_FIX_B;
      S_FIX_B:  if (mode_p) state_n = S_BRIGHT;
      default:  state_n = S_BRIGHT;  // unreachable codes recover
    endcase

    if (adj_en) begin
      case (state_q)
        S_BRIGHT: bright_n = inc_p ? pct_inc(bright_q) : pct_dec(bright_q);
        S_SPEED:  timer_n  = inc_p ? tmr_inc(timer_q)  : tmr_dec(timer_q);
        S_FIX_R:  r_n      = inc_p ? pct_inc(r_q)      : pct_dec(r_q);
        S_FIX_G:  g_n      = inc_p ? pct_inc(g_q)      : pct_dec(g_q);
        S_FIX_B:  b_n      = inc_p ? pct_inc(b_q)      : pct_dec(b_q);
        default:  ;
      endcase
    end

    fixed_n = (state_n == S_FIX_R) || (state_n == S_FIX_G) || (state_n == S_FIX_B);
  end

  assign bus.timer      = timer_q;
  assign bus.brightness = bright_q;
  assign bus.inverted   = inv_q;
  assign bus.fixed_mode = fixed_q;
  assign bus.duty_r     = r_q;
  assign bus.duty_g     = g_q;
  assign bus.duty_b     = b_q;
  assign bus.state      = state_q;

endmodule
